// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state encodings
// and the NOP word the instruction register resets to.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_CAPT  = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_t;

  localparam logic [15:0] NOP = 16'h0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, reads a single-cycle-latency BRAM,
// and hands each captured word to the decoder over a valid/ready handshake.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic [15:0]       mem_rd_data,
  output logic [15:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              halt
);

  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(1);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       ir;
  logic [ADDR_W-1:0] pc_capt;
  logic              handshake;

  assign handshake   = (state == ST_VALID) && instr_ready;
  assign instr_valid = (state == ST_VALID);
  assign mem_addr    = pc;
  assign mem_en      = (state == ST_REQ) && !halt && !reset;
  assign instr       = ir;
  assign pc_out      = pc_capt;

  always_comb begin
    state_next = state;
    case (state)
      ST_REQ:   if (!halt) state_next = ST_CAPT;
      ST_CAPT:  state_next = ST_VALID;
      ST_VALID: if (instr_ready) state_next = ST_REQ;
      default:  state_next = ST_REQ;
    endcase
    // A redirect abandons whatever is in flight or held and refetches.
    if (redirect) state_next = ST_REQ;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_REQ;
      pc      <= RESET_PC;
      ir      <= NOP;
      pc_capt <= RESET_PC;
    end else begin
      state <= state_next;
      if (redirect)
        pc <= redirect_target;
      else if (handshake)
        pc <= pc + PC_INC;
      // Capture stage: BRAM data for the address issued in REQ is valid now.
      if ((state == ST_CAPT) && !redirect) begin
        ir      <= mem_rd_data;
        pc_capt <= pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural single-cycle-latency BRAM.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_en;
  logic [15:0] mem_rd_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] pc_out;
  logic        redirect;
  logic [15:0] redirect_target;
  logic        halt;

  int vectors    = 0;
  int miscompares = 0;

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_addr        (mem_addr),
    .mem_en          (mem_en),
    .mem_rd_data     (mem_rd_data),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .pc_out          (pc_out),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halt            (halt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1234;
    if (a == 16'h0001) return 16'h5678;
    return a ^ 16'hC3C3;
  endfunction

  initial mem_rd_data = 16'hDEAD;
  always @(posedge clk) if (mem_en) mem_rd_data <= mem_word(mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; halt = 1'b0; instr_ready = 1'b1;
    redirect = 1'b0; redirect_target = 16'h0000;
    step(); step();
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_pc_out", pc_out, 16'h0000);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);

    // first fetch right after reset release
    reset = 1'b0; #1;
    chk("req0_mem_en", mem_en, 1'b1);
    step();
    chk("capt0_valid", instr_valid, 1'b0);
    step();
    chk("v0_valid", instr_valid, 1'b1);
    chk("v0_instr", instr, 16'h1234);
    chk("v0_pc_out", pc_out, 16'h0000);
    step(); step();
    chk("capt1_valid", instr_valid, 1'b0);
    step();
    chk("v1_valid", instr_valid, 1'b1);
    chk("v1_instr", instr, 16'h5678);
    chk("v1_pc_out", pc_out, 16'h0001);

    // decoder stall
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", instr_valid, 1'b1);
      chk("stall_instr", instr, 16'h5678);
      chk("stall_pc_out", pc_out, 16'h0001);
      chk("stall_mem_en", mem_en, 1'b0);
    end
    instr_ready = 1'b1;
    step();
    chk("resume_mem_en", mem_en, 1'b1);
    chk("resume_addr", mem_addr, 16'h0002);
    step(); step();
    chk("v2_instr", instr, 16'hC3C1);
    chk("v2_pc_out", pc_out, 16'h0002);

    // redirect together with handshake
    redirect = 1'b1; redirect_target = 16'h0040;
    step();
    redirect = 1'b0; #1;
    chk("jmp_addr", mem_addr, 16'h0040);
    chk("jmp_mem_en", mem_en, 1'b1);
    chk("jmp_valid", instr_valid, 1'b0);
    step(); step();
    chk("jmp_v_valid", instr_valid, 1'b1);
    chk("jmp_v_instr", instr, 16'hC383);
    chk("jmp_v_pc_out", pc_out, 16'h0040);

    // redirect while capturing 0x0041
    step();
    chk("pre_capt_addr", mem_addr, 16'h0041);
    step();
    redirect = 1'b1; redirect_target = 16'h0100;
    step();
    redirect = 1'b0; #1;
    chk("rcapt_valid", instr_valid, 1'b0);
    chk("rcapt_addr", mem_addr, 16'h0100);
    step();
    chk("rcapt_valid2", instr_valid, 1'b0);
    step();
    chk("rcapt_v_valid", instr_valid, 1'b1);
    chk("rcapt_v_instr", instr, 16'hC2C3);
    chk("rcapt_v_pc_out", pc_out, 16'h0100);

    // PC wrap at all-ones
    redirect = 1'b1; redirect_target = 16'hFFFF;
    step();
    redirect = 1'b0;
    step(); step();
    chk("ffff_instr", instr, 16'h3C3C);
    chk("ffff_pc_out", pc_out, 16'hFFFF);
    step();
    chk("wrap_addr", mem_addr, 16'h0000);
    chk("wrap_mem_en", mem_en, 1'b1);

    // halt in REQ
    halt = 1'b1; #1;
    chk("halt_mem_en0", mem_en, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halt_mem_en", mem_en, 1'b0);
      chk("halt_valid", instr_valid, 1'b0);
      chk("halt_addr", mem_addr, 16'h0000);
    end
    halt = 1'b0; #1;
    chk("unhalt_mem_en", mem_en, 1'b1);
    step(); step();
    chk("unhalt_instr", instr, 16'h1234);
    chk("unhalt_pc_out", pc_out, 16'h0000);
    step(); step(); step();
    chk("pre_rst_instr", instr, 16'h5678);
    chk("pre_rst_pc_out", pc_out, 16'h0001);

    // reset while an instruction is held in VALID
    instr_ready = 1'b0; reset = 1'b1;
    step();
    chk("vrst_valid", instr_valid, 1'b0);
    chk("vrst_addr", mem_addr, 16'h0000);
    chk("vrst_mem_en", mem_en, 1'b0);
    chk("vrst_instr", instr, 16'h0000);
    chk("vrst_pc_out", pc_out, 16'h0000);
    reset = 1'b0; instr_ready = 1'b1; #1;
    chk("vrst_rel_mem_en", mem_en, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer feeding the control FSM. Owns the program counter, issues reads to the single-cycle-latency instruction BRAM port, and captures each returned word in an instruction register. Presents the instruction to the decoder through a valid/ready handshake, and accepts PC redirects for branches and jumps.

## Interface
- ADDR_W, 16: width of PC and memory address.
- RESET_PC, 0: PC value loaded on reset.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_addr  out  ADDR_W  instruction memory address; equals current PC.
- mem_en  out  1  memory read enable.
- mem_rd_data  in  16  read data; valid one cycle after the address is sampled.
- instr  out  16  instruction register contents.
- instr_valid  out  1  instr holds a fetched, unconsumed instruction.
- instr_ready  in  1  decoder accepts instr this cycle.
- pc_out  out  ADDR_W  address the current instr was fetched from.
- redirect  in  1  load a new PC (branch/jump taken).
- redirect_target  in  ADDR_W  new PC value.
- halt  in  1  suppresses new fetches while high.

## Operation
- States: REQ, CAPT, VALID. Encoding 2 bits.
- REQ:
  - mem_en = !halt; mem_addr = pc.
  - If halt=0, go to CAPT; otherwise stay in REQ.
- CAPT:
  - mem_rd_data is valid; IR <= mem_rd_data; pc_out <= pc.
  - Go to VALID.
- VALID:
  - instr_valid=1.
  - Handshake completes when instr_valid & instr_ready.
  - On handshake: pc <= redirect ? redirect_target : pc+1; go to REQ.
  - Without handshake: hold instr, pc and pc_out stable.
- Redirect without handshake, in REQ, CAPT or VALID:
  - pc <= redirect_target.
  - Any in-flight or held instruction is discarded; instr_valid drops next cycle.
  - Go to REQ.
- Priority: reset > redirect > handshake > halt.
- Arithmetic: pc+1 is modulo 2^ADDR_W, so all-ones wraps to 0. No word/byte scaling.
- halt is sampled only in REQ.
  - A fetch already in CAPT completes.
  - An instruction in VALID remains consumable.
- Reset, including mid-fetch:
  - State REQ, pc=RESET_PC, IR=0, pc_out=RESET_PC, instr_valid=0.
  - mem_en=0 while reset is high.
  - The first fetch is issued in the first cycle after reset deasserts (if halt=0).

## Timing
- mem_addr and mem_en are combinational from pc/state; instr_valid is decoded from state. All other outputs are registered.
- Minimum fetch-to-valid latency is 2 cycles: REQ, then CAPT, then instr_valid.
- Peak throughput is 1 instruction per 3 cycles, with instr_ready held high.
- After a redirect with handshake, the first target instruction is valid 2 cycles after the REQ cycle at the target.
- mem_rd_data is ignored outside CAPT.
- instr stays stable while instr_valid=1 and no handshake or redirect has occurred.

## Structure
- Shared include fetch_defs.v (alongside instructionset.v) holds:
  - state encodings ST_REQ=2'd0, ST_CAPT=2'd1, ST_VALID=2'd2;
  - the NOP encoding 16'h0000 (IR reset value).
- Single module; PC register, IR and FSM are inline. No sub-module is warranted.

## Test plan
- Reset then release, mem holds 0x1234 at 0 and 0x5678 at 1, ready=1 -> instr 0x1234 valid with pc_out=0, then 0x5678 valid exactly 3 cycles later with pc_out=1.
- ready=0 for 5 cycles in VALID -> instr, pc_out and instr_valid unchanged and mem_en=0 throughout; fetch resumes the cycle after ready rises.
- Handshake with redirect=1, target=0x0040 -> mem_addr=0x0040 in the next cycle; the next instr comes from 0x0040, not pc+1.
- Redirect to 0x0100 during CAPT -> the captured word never becomes valid; the next valid instr has pc_out=0x0100.
- pc=0xFFFF consumed without redirect -> next mem_addr=0x0000.
- halt=1 in REQ for 4 cycles -> mem_en=0, state held; reset asserted in VALID -> instr_valid=0 and pc=RESET_PC next cycle.
